divu_serial: RTL and testbench

Multi-cycle unsigned divider for the MIPS datapath, serving DIVU and writing HI/LO. It performs restoring division, one quotient bit per clock. Each step is a WIDTH-bit ripple subtraction built from full-subtractor cells, the borrow-chain counterpart of the existing full-adder cell. The ALU control issues `start`, holds the pipeline while `busy` is high, and captures `quotient` (LO) and `remainder` (HI) on `done`.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fsubtractor.sv | 20 ++
 rtl/divu_serial.sv | 129 ++++++++++++
 tb/tb_divu_serial.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// +--------------------------------------------------------------------+
// | mips_pkg - shared divider state encoding, widths and /0 results     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam int DIVU_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Divide by zero: quotient is replicated from this bit, remainder is the dividend.
  localparam logic DIVZ_QUOT_BIT = 1'b1;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/fsubtractor.sv
// +--------------------------------------------------------------------+
// | fsubtractor - 1-bit full subtractor, {bout,diff} = inp1-inp2-bin    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module fsubtractor (
  output logic diff,
  output logic bout,
  input  logic inp1,
  input  logic inp2,
  input  logic bin
);

  assign diff = inp1 ^ inp2 ^ bin;
  assign bout = (~inp1 & (inp2 | bin)) | (inp2 & bin);

endmodule : fsubtractor

`default_nettype wire

// File: rtl/divu_serial.sv
// +--------------------------------------------------------------------+
// | divu_serial - restoring unsigned divider, one quotient bit / clock  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module divu_serial
  import mips_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_t;
  logic [WIDTH-1:0] step_diff;
  logic [WIDTH:0]   step_borrow;
  logic             step_take;
  logic             step_last;

  assign step_t         = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign step_borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    fsubtractor u_fsub (
      .diff (step_diff[i]),
      .bout (step_borrow[i+1]),
      .inp1 (step_t[i]),
      .inp2 (d_q[i]),
      .bin  (step_borrow[i])
    );
  end

  // The bit shifted out of R makes the partial remainder exceed D, so it forces the subtract.
  assign step_take = r_q[WIDTH-1] | ~step_borrow[WIDTH];
  assign step_last = (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      DIV_RUN: begin
        q_d     = {q_q[WIDTH-2:0], step_take};
        r_d     = step_take ? step_diff : step_t;
        count_d = count_q + CW'(1);
        if (step_last) begin
          state_d = DIV_DONE;
          count_d = '0;
          quot_d  = q_d;
          rem_d   = r_d;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        if (start) begin
          dbz_d = (divisor == '0);
          if (divisor == '0) begin
            state_d = DIV_DONE;
            quot_d  = {WIDTH{DIVZ_QUOT_BIT}};
            rem_d   = dividend;
          end else begin
            state_d = DIV_RUN;
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            count_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == DIV_RUN);
  assign done        = (state_q == DIV_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : divu_serial

`default_nettype wire

// File: tb/tb_divu_serial.sv
// +--------------------------------------------------------------------+
// | tb_divu_serial - randomized and directed checks for divu_serial     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_divu_serial;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;
  bit overlap = 1'b0;

  divu_serial #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Plain arithmetic reference for DIVU
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
  endtask

  // Cycles after the accept edge until done, bounded; also counts busy cycles.
  task automatic wait_done(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cycles++;
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
      tick();
      n++;
    end
    if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (quotient !== '0) begin bad++; $display("FAIL reset_quot: got %h expected 0", quotient); end
    total++; if (remainder !== '0) begin bad++; $display("FAIL reset_rem: got %h expected 0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W-1:0] eq, er;
    logic ez;
    int n, bc;
    va[0] = 32'd100;        vb[0] = 32'd7;
    va[1] = 32'hFFFF_FFFF;  vb[1] = 32'd1;
    va[2] = 32'h8000_0000;  vb[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      model(va[i], vb[i], eq, er, ez);
      issue(va[i], vb[i]);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL dir%0d_busy_after_accept: got %b expected 1", i, busy); end
      wait_done(n, bc);
      total++; if (n != W) begin bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, n, W); end
      total++; if (bc != W) begin bad++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, W); end
      total++; if (quotient !== eq) begin bad++; $display("FAIL dir%0d_quot: got %h expected %h", i, quotient, eq); end
      total++; if (remainder !== er) begin bad++; $display("FAIL dir%0d_rem: got %h expected %h", i, remainder, er); end
      total++; if (div_by_zero !== ez) begin bad++; $display("FAIL dir%0d_dbz: got %b expected %b", i, div_by_zero, ez); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done); end
      total++; if (quotient !== eq) begin bad++; $display("FAIL dir%0d_quot_hold: got %h expected %h", i, quotient, eq); end
    end
  endtask

  task automatic test_div_by_zero();
    issue(32'd5, 32'd0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL dz_done: got %b expected 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_busy: got %b expected 0", busy); end
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_quot: got %h expected ffffffff", quotient); end
    total++; if (remainder !== 32'd5) begin bad++; $display("FAIL dz_rem: got %h expected 5", remainder); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    // Another /0 accepted in the DONE cycle
    issue(32'd12, 32'd0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL dz_b2b_done: got %b expected 1", done); end
    total++; if (remainder !== 32'd12) begin bad++; $display("FAIL dz_b2b_rem: got %h expected c", remainder); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL dz_idle_done: got %b expected 0", done); end
    total++; if (remainder !== 32'd12) begin bad++; $display("FAIL dz_hold_rem: got %h expected c", remainder); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_hold_flag: got %b expected 1", div_by_zero); end
  endtask

  task automatic test_ignore_start();
    int n, bc;
    issue(32'd3, 32'd10);
    repeat (9) tick();
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    tick();
    start = 1'b0;
    wait_done(n, bc);
    total++; if (n + 10 != W) begin bad++; $display("FAIL ign_latency: got %0d expected %0d", n + 10, W); end
    total++; if (quotient !== 32'd0) begin bad++; $display("FAIL ign_quot: got %h expected 0", quotient); end
    total++; if (remainder !== 32'd3) begin bad++; $display("FAIL ign_rem: got %h expected 3", remainder); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_queue: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int n, bc;
    bit saw_done;
    issue(32'd1000, 32'd3);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    total++; if (quotient !== '0) begin bad++; $display("FAIL rst_mid_quot: got %h expected 0", quotient); end
    total++; if (remainder !== '0) begin bad++; $display("FAIL rst_mid_rem: got %h expected 0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_mid_dbz: got %b expected 0", div_by_zero); end
    saw_done = 1'b0;
    repeat (2) begin tick(); if (done !== 1'b0) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (40) begin tick(); if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1; end
    total++; if (saw_done) begin bad++; $display("FAIL rst_mid_abandon: got activity=1 expected 0"); end
    issue(32'd1000, 32'd3);
    wait_done(n, bc);
    total++; if (quotient !== 32'd333) begin bad++; $display("FAIL rst_restart_quot: got %h expected 14d", quotient); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL rst_restart_rem: got %h expected 1", remainder); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, bc;
    issue(32'd9, 32'd2);
    wait_done(n, bc);
    total++; if (quotient !== 32'd4 || remainder !== 32'd1) begin bad++; $display("FAIL b2b_first: got %h/%h expected 4/1", quotient, remainder); end
    issue(32'd7, 32'd7);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done); end
    wait_done(n, bc);
    total++; if (n != W) begin bad++; $display("FAIL b2b_latency: got %0d expected %0d", n, W); end
    total++; if (quotient !== 32'd1 || remainder !== 32'd0) begin bad++; $display("FAIL b2b_second: got %h/%h expected 1/0", quotient, remainder); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic ez;
    int n, bc, want;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = '0;
        default: b = a >> $urandom_range(0, 31);
      endcase
      model(a, b, eq, er, ez);
      want = ez ? 0 : W;
      issue(a, b);
      wait_done(n, bc);
      total++; if (n != want) begin bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, n, want); end
      total++; if (quotient !== eq || remainder !== er) begin bad++; $display("FAIL rnd%0d_result %h/%h: got %h,%h expected %h,%h", i, a, b, quotient, remainder, eq, er); end
      total++; if (div_by_zero !== ez) begin bad++; $display("FAIL rnd%0d_dbz: got %b expected %b", i, div_by_zero, ez); end
      if ($urandom_range(0, 1) == 0) tick();
    end
    total++; if (overlap) begin bad++; $display("FAIL busy_done_overlap: got 1 expected 0"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_divu_serial

`default_nettype wire
